// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam logic [2:0] ECHO_GRANT_ID = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StWait
  } state_e;

  // Round-robin successor of a source index, wrapping at num_req.
  function automatic logic [2:0] next_ptr(input logic [2:0] cur, input int unsigned num_req);
    return (({29'd0, cur} + 32'd1) >= num_req) ? 3'd0 : cur + 3'd1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream handshake between message sources and the UART transmit arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);

  logic [NUM_REQ-1:0]                  req;
  logic [NUM_REQ*uart_pkg::BYTE_W-1:0] req_data;
  logic [NUM_REQ-1:0]                  req_last;
  logic [NUM_REQ-1:0]                  req_ack;

  modport master (output req, req_data, req_last, input req_ack);
  modport slave  (input req, req_data, req_last, output req_ack);

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search starting at rr_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         rr_ptr,
  output logic               valid,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [2:0]         grant_idx
);

  int idx;

  always_comb begin
    valid     = 1'b0;
    grant_oh  = '0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
      if (!valid && req[idx]) begin
        valid         = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_idx     = 3'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ message sources.
// Optional RX echo FIFO is built when UART_ECHO_EN is defined.
module uart_tx_arbiter import uart_pkg::*; #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 2_000_000,
  parameter int unsigned ECHO_DEPTH  = 4
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_arbiter_if.slave    src,
  output logic [2:0]          grant_id,
  output logic                busy,
  output logic                tx_start,
  output logic [BYTE_W-1:0]   tx_data,
  input  logic                tx_busy,
  input  logic                tx_done,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_done,
  output logic                timeout_err,
  output logic                echo_overflow
);

  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);

  state_e              state_q, state_d;
  logic [2:0]          grant_q, grant_d, rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic                last_q, last_d, echo_q, echo_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic [WdW-1:0]      wdog_q, wdog_d;
  logic                timeout_err_q, timeout_err_d;

  logic                arb_valid;
  logic [NUM_REQ-1:0]  arb_oh;
  logic [2:0]          arb_idx;
  logic                ack, echo_avail, echo_pop;
  logic [BYTE_W-1:0]   echo_head, cur_byte;
  logic                cur_req, cur_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (src.req),
    .rr_ptr    (rr_ptr_q),
    .valid     (arb_valid),
    .grant_oh  (arb_oh),
    .grant_idx (arb_idx)
  );

  // Echo bytes are parked in tx_data_q at grant time, so SEND needs no source lookup.
  always_comb begin
    cur_byte = '0;
    cur_req  = 1'b0;
    cur_last = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_oh_q[i]) begin
        cur_byte = src.req_data[i*BYTE_W +: BYTE_W];
        cur_req  = src.req[i];
        cur_last = src.req_last[i];
      end
    end
    if (echo_q) begin
      cur_byte = tx_data_q;
      cur_req  = 1'b1;
      cur_last = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_oh_d    = grant_oh_q;
    rr_ptr_d      = rr_ptr_q;
    last_d        = last_q;
    echo_d        = echo_q;
    tx_data_d     = tx_data_q;
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q;
    tx_start      = 1'b0;
    ack           = 1'b0;
    echo_pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (echo_avail) begin
          echo_pop   = 1'b1;
          echo_d     = 1'b1;
          grant_d    = ECHO_GRANT_ID;
          grant_oh_d = '0;
          tx_data_d  = echo_head;
          state_d    = StSend;
        end else if (arb_valid) begin
          echo_d     = 1'b0;
          grant_d    = arb_idx;
          grant_oh_d = arb_oh;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (!tx_busy) begin
          if (cur_req) begin
            tx_start  = 1'b1;
            ack       = ~echo_q;
            tx_data_d = cur_byte;
            last_d    = cur_last;
            wdog_d    = '0;
            state_d   = StWait;
          end else begin
            rr_ptr_d = next_ptr(grant_q, NUM_REQ);
            state_d  = StIdle;
          end
        end
      end
      StWait: begin
        if (tx_done) begin
          if (last_q) begin
            if (!echo_q) rr_ptr_d = next_ptr(grant_q, NUM_REQ);
            state_d = StIdle;
          end else begin
            state_d = StSend;
          end
        end else if (wdog_q == WdW'(TIMEOUT_CYC - 1)) begin
          timeout_err_d = 1'b1;
          if (!echo_q) rr_ptr_d = next_ptr(grant_q, NUM_REQ);
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      grant_oh_q    <= '0;
      rr_ptr_q      <= '0;
      last_q        <= 1'b0;
      echo_q        <= 1'b0;
      tx_data_q     <= '0;
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_oh_q    <= grant_oh_d;
      rr_ptr_q      <= rr_ptr_d;
      last_q        <= last_d;
      echo_q        <= echo_d;
      tx_data_q     <= tx_data_d;
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign grant_id    = grant_q;
  assign tx_data     = (state_q == StSend) ? cur_byte : tx_data_q;
  assign src.req_ack = ack ? grant_oh_q : '0;
  assign timeout_err = timeout_err_q;

`ifdef UART_ECHO_EN
  localparam int unsigned EchoAw = $clog2(ECHO_DEPTH);

  logic [BYTE_W-1:0] echo_mem_q [ECHO_DEPTH];
  logic [EchoAw:0]   echo_wr_q, echo_wr_d, echo_rd_q, echo_rd_d;
  logic              echo_ovf_q, echo_ovf_d;
  logic              echo_full, echo_push;

  assign echo_avail = (echo_wr_q != echo_rd_q);
  assign echo_full  = (echo_wr_q[EchoAw] != echo_rd_q[EchoAw]) &&
                      (echo_wr_q[EchoAw-1:0] == echo_rd_q[EchoAw-1:0]);
  // A pop in the same cycle frees the slot, so push-at-full is accepted then.
  assign echo_push  = rx_done && (!echo_full || echo_pop);
  assign echo_head  = echo_mem_q[echo_rd_q[EchoAw-1:0]];

  always_comb begin
    echo_wr_d  = echo_push ? echo_wr_q + 1'b1 : echo_wr_q;
    echo_rd_d  = echo_pop ? echo_rd_q + 1'b1 : echo_rd_q;
    echo_ovf_d = echo_ovf_q | (rx_done & echo_full & ~echo_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_wr_q  <= '0;
      echo_rd_q  <= '0;
      echo_ovf_q <= 1'b0;
    end else begin
      echo_wr_q  <= echo_wr_d;
      echo_rd_q  <= echo_rd_d;
      echo_ovf_q <= echo_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (echo_push) echo_mem_q[echo_wr_q[EchoAw-1:0]] <= rx_data;
  end

  assign echo_overflow = echo_ovf_q;
`else
  logic unused_echo;
  assign echo_avail    = 1'b0;
  assign echo_head     = '0;
  assign echo_overflow = 1'b0;
  assign unused_echo   = ^{rx_data, rx_done, echo_pop, (ECHO_DEPTH != 0)};
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: byte-queue sources and a tx model against a message-level round-robin model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned TOUT = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_busy, tx_done, rx_done;
  logic [7:0] rx_data, tx_data;
  logic [2:0] grant_id;
  logic       busy, tx_start, timeout_err, echo_overflow;

  uart_tx_arbiter_if #(.NUM_REQ(NREQ)) src_if ();

  uart_tx_arbiter #(.NUM_REQ(NREQ), .TIMEOUT_CYC(TOUT), .ECHO_DEPTH(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .src           (src_if),
    .grant_id      (grant_id),
    .busy          (busy),
    .tx_start      (tx_start),
    .tx_data       (tx_data),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .timeout_err   (timeout_err),
    .echo_overflow (echo_overflow)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int checks = 0;

  logic [8:0]  src_mem [NREQ][64];
  int          head [NREQ];
  int          tail [NREQ];
  logic        src_en [NREQ];
  int          ack_cnt [NREQ];
  int          n_start, cyc, start_cyc, model_ptr, fixed_lat, tx_cnt;
  logic        hold_busy, suppress_done, mbusy;
  logic [10:0] mon_q [$];
  logic [10:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  function automatic bit pending();
    bit p = 0;
    for (int i = 0; i < NREQ; i++) if (src_en[i] && head[i] != tail[i]) p = 1;
    return p;
  endfunction

  task automatic push_byte(input int s, input logic [7:0] b, input logic last);
    src_mem[s][tail[s] % 64] = {last, b};
    tail[s]++;
  endtask

  task automatic push_msg(input int s, input int len);
    for (int k = 0; k < len; k++) push_byte(s, 8'($urandom), k == len - 1);
  endtask

  // Whole messages leave in round-robin order; each winner moves the pointer past itself.
  task automatic run_model();
    int  h [NREQ];
    int  s;
    bit  found;
    for (int i = 0; i < NREQ; i++) h[i] = head[i];
    s = 0;
    do begin
      found = 0;
      for (int k = 0; k < NREQ && !found; k++) begin
        s = (model_ptr + k) % NREQ;
        if (h[s] != tail[s]) found = 1;
      end
      if (found) begin
        logic [8:0] e;
        do begin
          e = src_mem[s][h[s] % 64];
          h[s]++;
          exp_q.push_back({3'(s), e[7:0]});
        end while (!e[8] && h[s] != tail[s]);
        model_ptr = (s + 1) % NREQ;
      end
    end while (found);
  endtask

  task automatic compare_streams(input string tag);
    chk({tag, "_count"}, mon_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) chk(tag, mon_q[k], exp_q[k]);
    mon_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      tick();
      n++;
      if (!busy && !mbusy && !pending()) quiet++;
      else quiet = 0;
    end
    chk({tag, "_drain"}, n < budget, 1);
  endtask

  // Environment: monitor at negedge, then sources and tx model update just after posedge.
  initial begin : env
    logic [NREQ-1:0] s_ack;
    logic            s_start, s_txb;
    logic [7:0]      s_data;
    logic [2:0]      s_gid;
    mbusy = 0; tx_cnt = 0; tx_done = 0; tx_busy = 0; cyc = 0; n_start = 0; start_cyc = 0;
    src_if.req = '0; src_if.req_data = '0; src_if.req_last = '0;
    forever begin
      @(negedge clk);
      cyc++;
      s_ack = src_if.req_ack; s_start = tx_start; s_data = tx_data;
      s_gid = grant_id; s_txb = tx_busy;
      if (!reset) begin
        if (s_start) begin
          mon_q.push_back({s_gid, s_data});
          n_start++;
          start_cyc = cyc;
          chk("start_while_tx_busy", s_txb, 0);
        end
        if (s_ack != '0) chk("ack_only_granted", s_ack, s_start ? (32'd1 << s_gid) : 32'd0);
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) if (s_ack[i] && !reset) begin
        head[i]++;
        ack_cnt[i]++;
      end
      tx_done = 0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_done = 1;
          mbusy = 0;
        end
      end
      if (s_start && !suppress_done && !reset) begin
        mbusy = 1;
        tx_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 12));
      end
      tx_busy = mbusy | hold_busy;
      for (int i = 0; i < NREQ; i++) begin
        src_if.req[i] = src_en[i] && (head[i] != tail[i]);
        src_if.req_data[i*8 +: 8] = src_mem[i][head[i] % 64][7:0];
        src_if.req_last[i] = src_mem[i][head[i] % 64][8];
      end
    end
  end

  initial begin : main
    int k, n0, a0;
    reset = 1; rx_data = 0; rx_done = 0; hold_busy = 0; suppress_done = 0;
    fixed_lat = 0; model_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      head[i] = 0; tail[i] = 0; src_en[i] = 1; ack_cnt[i] = 0;
    end
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_req_ack", src_if.req_ack, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_echo_overflow", echo_overflow, 0);
    reset = 0;
    tick();

    // "OK\n" from source 1, tx_done 10 cycles after each start.
    fixed_lat = 10;
    push_byte(1, 8'h4F, 0); push_byte(1, 8'h4B, 0); push_byte(1, 8'h0A, 1);
    run_model();
    wait_idle("single", 400);
    compare_streams("single");
    chk("single_acks", ack_cnt[1], 3);
    chk("single_busy_low", busy, 0);

    // Sources 0 and 2 compete; pointer is now 2, so source 2 leads.
    fixed_lat = 0;
    push_msg(0, 1); push_msg(2, 2); push_msg(0, 1); push_msg(2, 1);
    run_model();
    wait_idle("fair", 600);
    chk("rr_ptr_after_single", (mon_q.size() > 0) ? 32'(mon_q[0][10:8]) : 32'd99, 2);
    compare_streams("fair");

    // Transmitter busy for 50 cycles while a byte waits.
    hold_busy = 1;
    n0 = n_start;
    push_msg(3, 1);
    run_model();
    repeat (50) tick();
    chk("hold_no_start", n_start - n0, 0);
    chk("hold_busy_flag", busy, 1);
    hold_busy = 0;
    k = 0;
    while (n_start == n0 && k < 10) begin tick(); k++; end
    chk("hold_release_latency", k, 1);
    wait_idle("hold", 200);
    compare_streams("hold");

    // Watchdog: first message never completes; the next requester is still served.
    suppress_done = 1;
    push_msg(1, 1); push_msg(2, 1);
    run_model();
    k = 0;
    while (!timeout_err && k < 400) begin tick(); k++; end
    chk("wdog_flag", timeout_err, 1);
    chk("wdog_delay", (cyc - start_cyc >= 100) && (cyc - start_cyc <= 101), 1);
    chk("wdog_idle", busy, 0);
    suppress_done = 0;
    wait_idle("wdog", 400);
    compare_streams("wdog");
    chk("wdog_sticky", timeout_err, 1);

    // Source 3 drops req after its first byte of a two-byte message.
    fixed_lat = 10;
    a0 = ack_cnt[3];
    push_byte(3, 8'hA5, 0); push_byte(3, 8'h5A, 1);
    exp_q.push_back({3'd3, 8'hA5});
    k = 0;
    while (ack_cnt[3] == a0 && k < 100) begin tick(); k++; end
    src_en[3] = 0;
    wait_idle("abort", 200);
    chk("abort_acks", ack_cnt[3] - a0, 1);
    compare_streams("abort");
    head[3] = tail[3];
    src_en[3] = 1;
    model_ptr = 0;

    // Randomized traffic, several rounds.
    fixed_lat = 0;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < NREQ; s++) begin
        if ($urandom_range(0, 1) == 1) push_msg(s, int'($urandom_range(1, 3)));
        if ($urandom_range(0, 3) == 0) push_msg(s, int'($urandom_range(1, 3)));
      end
      run_model();
      wait_idle("rand", 2000);
      compare_streams("rand");
    end

`ifdef UART_ECHO_EN
    // Five received bytes during a locked message: four echo afterwards, one overflows.
    fixed_lat = 10;
    a0 = ack_cnt[0];
    push_msg(0, 3);
    run_model();
    k = 0;
    while (ack_cnt[0] == a0 && k < 100) begin tick(); k++; end
    rx_data = 8'h55;
    rx_done = 1;
    repeat (5) tick();
    rx_done = 0;
    for (int e = 0; e < 4; e++) exp_q.push_back({ECHO_GRANT_ID, 8'h55});
    wait_idle("echo", 600);
    compare_streams("echo");
    chk("echo_overflow", echo_overflow, 1);
    chk("echo_no_ack", ack_cnt[0] - a0, 3);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
